pll_lock_supervisor: RTL and testbench

//  Control-side partner to the ECP5 EHXPLLL clock generators: drives PLL RST, qualifies the

---
 rtl/pll_lock_supervisor_pkg.sv | 23 ++
 rtl/pll_lock_supervisor_if.sv | 23 ++
 rtl/pll_lock_supervisor_sync.sv | 18 +
 rtl/pll_lock_supervisor.sv | 100 ++++++++++
 tb/tb_pll_lock_supervisor.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types for the PLL lock supervisor: FSM state encoding and counter sizing.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // One counter serves every state, so it must cover the longest interval.
  function automatic int cnt_w(input int lock_timeout, input int stable_cycles,
                               input int rst_cycles);
    int m;
    m = $clog2(lock_timeout);
    if ($clog2(stable_cycles) > m) m = $clog2(stable_cycles);
    if ($clog2(rst_cycles) > m) m = $clog2(rst_cycles);
    if (m < 1) m = 1;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and reset-side signals of the supervisor.
// LOCK_LOSS_COUNT_EN adds the lock_loss_cnt bus.
interface pll_lock_supervisor_if #(
  parameter int RC_W = 3
);
  logic            pll_locked;
  logic            pll_rst;
  logic            sys_reset;
  logic            ready;
  logic            fault;
  logic [RC_W-1:0] retry_count;
`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0]      lock_loss_cnt;

  modport master (input pll_locked, output pll_rst, sys_reset, ready, fault, retry_count,
                  lock_loss_cnt);
  modport slave  (output pll_locked, input pll_rst, sys_reset, ready, fault, retry_count,
                  lock_loss_cnt);
`else
  modport master (input pll_locked, output pll_rst, sys_reset, ready, fault, retry_count);
  modport slave  (output pll_locked, input pll_rst, sys_reset, ready, fault, retry_count);
`endif
endinterface

// File: rtl/pll_lock_supervisor_sync.sv
// Multi-flop synchronizer for the asynchronous PLL LOCK signal; clears to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_sync <= '0;
    else            r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock and gates the downstream reset; retries then faults.
// Optional `LOCK_LOSS_COUNT_EN adds a saturating RUN->RESET event counter.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 250000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  pll_lock_supervisor_if.master io_sup
);
  localparam int CNT_W = cnt_w(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES);
  localparam int RC_W  = $clog2(MAX_RETRIES + 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [RC_W-1:0]  r_retry, w_retry_nxt;
  logic             w_lock_s;
  logic             r_pll_rst, r_sys_reset, r_ready, r_fault;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_d       (io_sup.pll_locked),
    .o_q       (w_lock_s)
  );

  always_comb begin
    w_next      = r_state;
    w_retry_nxt = r_retry;
    case (r_state)
      RESET:     if (r_cnt == CNT_W'(RST_CYCLES - 1)) w_next = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle takes priority over the retry.
        if (w_lock_s) w_next = STABLE;
        else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          if (r_retry != RC_W'(MAX_RETRIES)) w_retry_nxt = r_retry + RC_W'(1);
          w_next = (w_retry_nxt == RC_W'(MAX_RETRIES)) ? FAULT : RESET;
        end
      end
      STABLE: begin
        if (!w_lock_s) w_next = WAIT_LOCK;
        else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) w_next = RUN;
      end
      RUN:     if (!w_lock_s) w_next = RESET;
      FAULT:   w_next = FAULT;
      default: w_next = RESET;
    endcase
    if (w_next == RUN && r_state != RUN) w_retry_nxt = '0;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= RESET;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
      r_retry <= w_retry_nxt;
    end
  end

  // Outputs decode the next state so RUN entry and lock loss show up in the same cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pll_rst   <= 1'b1;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_pll_rst   <= (w_next == RESET) || (w_next == FAULT);
      r_sys_reset <= (w_next != RUN);
      r_ready     <= (w_next == RUN);
      r_fault     <= r_fault | (w_next == FAULT);
    end
  end

  assign io_sup.pll_rst     = r_pll_rst;
  assign io_sup.sys_reset   = r_sys_reset;
  assign io_sup.ready       = r_ready;
  assign io_sup.fault       = r_fault;
  assign io_sup.retry_count = r_retry;

`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] r_loss_cnt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_loss_cnt <= '0;
    else if (r_state == RUN && w_next == RESET && r_loss_cnt != 8'hFF)
      r_loss_cnt <= r_loss_cnt + 8'd1;
  end

  assign io_sup.lock_loss_cnt = r_loss_cnt;
`endif
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: expected (cycle, signal, value) entries are queued when stimulus is
// driven and checked on the falling edge of the cycle they fall due.
module tb_pll_lock_supervisor;
  localparam int K_PLL_RST = 0, K_SYS = 1, K_READY = 2, K_FAULT = 3, K_RETRY = 4, K_LLC = 5;

  typedef struct {
    int cyc;
    int kind;
    int exp;
  } exp_t;

  logic  clk;
  logic  rst_n;
  int    cyc;
  int    n_tests;
  int    n_fail;
  int    b;
  exp_t  sbq[$];
  string tq[$];
  exp_t  me;
  string mt;

  pll_lock_supervisor_if #(.RC_W(2)) sup ();

  pll_lock_supervisor #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(3), .SYNC_STAGES(2)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io_sup    (sup)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int kind, input int exp, input string tag);
    exp_t e;
    e.cyc = c; e.kind = kind; e.exp = exp;
    sbq.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int actual(input int kind);
    case (kind)
      K_PLL_RST: return int'(sup.pll_rst);
      K_SYS:     return int'(sup.sys_reset);
      K_READY:   return int'(sup.ready);
      K_FAULT:   return int'(sup.fault);
      K_RETRY:   return int'(sup.retry_count);
`ifdef LOCK_LOSS_COUNT_EN
      K_LLC:     return int'(sup.lock_loss_cnt);
`endif
      default:   return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      me = sbq.pop_front();
      mt = tq.pop_front();
      if (me.cyc < cyc) chk({mt, "_missed"}, cyc, me.cyc);
      else              chk(mt, actual(me.kind), me.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: stuck at cycle %0d, expected end before time limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    sup.pll_locked = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    push(cyc, K_PLL_RST, 1, "t1_pll_rst");
    push(cyc, K_SYS,     1, "t1_sys_reset");
    push(cyc, K_READY,   0, "t1_ready");
    push(cyc, K_FAULT,   0, "t1_fault");
    push(cyc, K_RETRY,   0, "t1_retry");
`ifdef LOCK_LOSS_COUNT_EN
    push(cyc, K_LLC,     0, "t1_llc");
`endif
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    b = cyc;

    // first lock: pll_rst low after 4 cycles, ready 2+8 cycles after lock sampled
    push(b + 3,  K_PLL_RST, 1, "t2_pll_rst_hold");
    push(b + 4,  K_PLL_RST, 0, "t2_pll_rst_rel");
    push(b + 4,  K_SYS,     1, "t2_sys_hold");
    push(b + 15, K_READY,   0, "t2_ready_early");
    push(b + 16, K_READY,   1, "t2_ready");
    push(b + 16, K_SYS,     0, "t2_sys_rel");
    wait_cyc(b + 5);
    sup.pll_locked = 1'b1;
    wait_cyc(b + 20);

    // single-cycle lock glitch in RUN forces a full restart
    b = cyc;
    push(b + 2,  K_SYS,     0, "t3_sys_before");
    push(b + 3,  K_SYS,     1, "t3_sys_react");
    push(b + 3,  K_READY,   0, "t3_ready_drop");
`ifdef LOCK_LOSS_COUNT_EN
    push(b + 3,  K_LLC,     1, "t3_llc");
`endif
    push(b + 4,  K_PLL_RST, 1, "t3_pll_rst");
    push(b + 7,  K_PLL_RST, 0, "t3_pll_rst_rel");
    push(b + 16, K_READY,   1, "t3_ready_back");
    sup.pll_locked = 1'b0;
    wait_cyc(b + 1);
    sup.pll_locked = 1'b1;
    wait_cyc(b + 20);

    // lock lost inside STABLE, then held low through three timeouts into FAULT
    b = cyc;
    push(b + 3,   K_SYS,     1, "t4_sys");
`ifdef LOCK_LOSS_COUNT_EN
    push(b + 3,   K_LLC,     2, "t4_llc");
`endif
    push(b + 9,   K_PLL_RST, 0, "t4_pll_rst_wait");
    push(b + 14,  K_PLL_RST, 0, "t4_pll_rst_stable");
    push(b + 14,  K_READY,   0, "t4_ready_stable");
    push(b + 15,  K_READY,   0, "t4_ready_back");
    push(b + 15,  K_RETRY,   0, "t4_retry");
    push(b + 15,  K_SYS,     1, "t4_sys_back");
    push(b + 34,  K_RETRY,   0, "t5_retry_pre");
    push(b + 35,  K_RETRY,   1, "t5_retry1");
    push(b + 35,  K_PLL_RST, 1, "t5_pll_rst1");
    push(b + 39,  K_PLL_RST, 0, "t5_pll_rst_rel");
    push(b + 58,  K_RETRY,   1, "t5_retry1_hold");
    push(b + 59,  K_RETRY,   2, "t5_retry2");
    push(b + 82,  K_FAULT,   0, "t5_fault_pre");
    push(b + 83,  K_FAULT,   1, "t5_fault");
    push(b + 83,  K_RETRY,   3, "t5_retry3");
    push(b + 83,  K_PLL_RST, 1, "t5_pll_rst_fault");
    push(b + 100, K_FAULT,   1, "t5_fault_sticky");
    push(b + 100, K_PLL_RST, 1, "t5_pll_rst_sticky");
    push(b + 100, K_SYS,     1, "t5_sys_sticky");
    push(b + 100, K_READY,   0, "t5_ready_sticky");
`ifdef LOCK_LOSS_COUNT_EN
    push(b + 100, K_LLC,     2, "t5_llc");
`endif
    sup.pll_locked = 1'b0;
    wait_cyc(b + 7);
    sup.pll_locked = 1'b1;
    wait_cyc(b + 12);
    sup.pll_locked = 1'b0;
    wait_cyc(b + 90);
    sup.pll_locked = 1'b1;
    wait_cyc(b + 101);

    // asynchronous reset mid-cycle clears fault before any clock edge
    b = cyc;
    push(b, K_FAULT,   0, "t6_async_fault");
    push(b, K_PLL_RST, 1, "t6_async_pll_rst");
    push(b, K_RETRY,   0, "t6_async_retry");
`ifdef LOCK_LOSS_COUNT_EN
    push(b, K_LLC,     0, "t6_async_llc");
`endif
    rst_n = 1'b0;
    sup.pll_locked = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    b = cyc;

    // one timeout, then lock arriving on the last cycle of the second WAIT_LOCK
    push(b + 24, K_RETRY,   1, "t7_retry1");
    push(b + 47, K_RETRY,   1, "t7_retry_pre");
    push(b + 47, K_PLL_RST, 0, "t7_pll_rst_pre");
    push(b + 48, K_RETRY,   1, "t7_retry_edge");
    push(b + 48, K_PLL_RST, 0, "t7_pll_rst_edge");
    push(b + 55, K_READY,   0, "t7_ready_early");
    push(b + 56, K_READY,   1, "t7_ready");
    push(b + 56, K_RETRY,   0, "t7_retry_clr");
    push(b + 56, K_SYS,     0, "t7_sys_rel");
    wait_cyc(b + 45);
    sup.pll_locked = 1'b1;
    wait_cyc(b + 60);

    while (sbq.size() > 0) begin
      me = sbq.pop_front();
      mt = tq.pop_front();
      chk({mt, "_unreached"}, cyc, me.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
